median: RTL and testbench

- Streaming 3x3 median filter for 8-bit greyscale images, placed in the pixel pipeline between the raster pixel source and the denoised-pixel sink.
- Accepts one pixel per clock in raster order.
- Keeps two line buffers plus a 3x3 window register set.
- Outputs the median of the 9 window pixels each clock, to suppress salt-and-pepper noise.

---
 rtl/median.sv | 60 ++++++
 tb/tb_median.sv | 97 +++++++++
 2 files changed

// File: rtl/median.sv
// median: streaming 3x3 median filter over a raster pixel stream,
//   two shift-register line buffers feeding a 3x3 window and a 19-exchange sorting network.
module median #(
   parameter int IMG_WIDTH = 3,
   parameter int PIX_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pixel_in,
   output logic [PIX_W-1:0] pixel_out
);
   localparam logic [3:0] A [19] = '{4'd1, 4'd4, 4'd7, 4'd0, 4'd3, 4'd6, 4'd1, 4'd4, 4'd7, 4'd0,
                                     4'd5, 4'd4, 4'd3, 4'd1, 4'd2, 4'd4, 4'd4, 4'd6, 4'd4};
   localparam logic [3:0] B [19] = '{4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd2, 4'd5, 4'd8, 4'd3,
                                     4'd8, 4'd7, 4'd6, 4'd4, 4'd5, 4'd7, 4'd2, 4'd4, 4'd2};
   logic [PIX_W-1:0] lb1 [IMG_WIDTH];
   logic [PIX_W-1:0] lb2 [IMG_WIDTH];
   logic [PIX_W-1:0] win [9];
   logic [PIX_W-1:0] v   [9];
   logic [PIX_W-1:0] med;
   // win[3r+c] is row r (0 = newest), column c (0 = newest)
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         for (int i = 0; i < IMG_WIDTH; i++) begin
            lb1[i] <= '0;
            lb2[i] <= '0;
         end
         for (int i = 0; i < 9; i++) win[i] <= '0;
         pixel_out <= '0;
      end else begin
         lb1[0] <= pixel_in;
         lb2[0] <= lb1[IMG_WIDTH-1];
         for (int i = 1; i < IMG_WIDTH; i++) begin
            lb1[i] <= lb1[i-1];
            lb2[i] <= lb2[i-1];
         end
         win[0] <= pixel_in;
         win[3] <= lb1[IMG_WIDTH-1];
         win[6] <= lb2[IMG_WIDTH-1];
         for (int r = 0; r < 3; r++) begin
            win[3*r+1] <= win[3*r];
            win[3*r+2] <= win[3*r+1];
         end
         pixel_out <= med;
      end
   // each exchange leaves the smaller value at A[i]; v[4] ends up as the median
   always_comb begin : sort_net
      logic [PIX_W-1:0] lo, hi;
      lo = '0;
      hi = '0;
      v  = win;
      for (int i = 0; i < 19; i++) begin
         lo = (v[A[i]] < v[B[i]]) ? v[A[i]] : v[B[i]];
         hi = (v[A[i]] < v[B[i]]) ? v[B[i]] : v[A[i]];
         v[A[i]] = lo;
         v[B[i]] = hi;
      end
      med = v[4];
   end
endmodule

// File: tb/tb_median.sv
// tb_median: directed vectors for median at IMG_WIDTH 3 and 5; expected outputs are queued
//   with the cycle they are due and checked by an independent monitor.
module tb_median;
   typedef struct {
      int    due;
      int    dut;
      int    val;
      string nm;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pixel_in = 8'd0;
   logic [7:0] out3, out5;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   exp_t       q [$];
   exp_t       e;
   int         act;
   median #(.IMG_WIDTH(3), .PIX_W(8)) d3 (.clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_out(out3));
   median #(.IMG_WIDTH(5), .PIX_W(8)) d5 (.clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_out(out5));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      while (q.size() > 0 && q[0].due <= cyc) begin
         e   = q.pop_front();
         act = (e.dut == 5) ? int'(out5) : int'(out3);
         n_cmp++;
         if (e.due != cyc || act != e.val) begin
            n_bad++;
            $display("FAIL %s w%0d cyc %0d (due %0d): got %0d expected %0d", e.nm, e.dut, cyc, e.due, act, e.val);
         end
      end
   task automatic chk(input string nm, input int a, input int x);
      n_cmp++;
      if (a != x) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, a, x);
      end
   endtask
   task automatic drive(input int p, input int e3, input int e5, input string nm);
      @(negedge clk);
      pixel_in = p[7:0];
      if (e3 >= 0) q.push_back('{due: cyc + 2, dut: 3, val: e3, nm: nm});
      if (e5 >= 0) q.push_back('{due: cyc + 2, dut: 5, val: e5, nm: nm});
   endtask
   task automatic reset_pulse();
      repeat (3) @(negedge clk);
      pixel_in = 8'd0;
      rst = 1'b0;
      #1;
      chk("reset_w3", int'(out3), 0);
      chk("reset_w5", int'(out5), 0);
      @(negedge clk);
      rst = 1'b1;
   endtask
   initial begin
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pixel_in = i[0] ? 8'h00 : 8'hFF;
         #1;
         chk("rst_hold_w3", int'(out3), 0);
         chk("rst_hold_w5", int'(out5), 0);
      end
      pixel_in = 8'd0;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 9; k++) drive(10 * k, (k <= 4) ? 0 : 10 * (k - 4), -1, "ramp");
      for (int j = 1; j <= 9; j++) drive(100, (j <= 4) ? 50 + 10 * j : 100, -1, "impulse_fill");
      drive(255, 100, -1, "impulse_hi");
      for (int j = 0; j < 4; j++) drive(100, 100, -1, "impulse_mid");
      drive(0, 100, -1, "impulse_lo");
      for (int j = 0; j < 9; j++) drive(100, 100, -1, "impulse_tail");
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_clear_w3", int'(out3), 0);
      chk("async_clear_w5", int'(out5), 0);
      @(negedge clk);
      chk("async_hold_w3", int'(out3), 0);
      pixel_in = 8'd0;
      rst = 1'b1;
      for (int k = 1; k <= 8; k++) drive(200, (k <= 4) ? 0 : 200, -1, "refill_200");
      reset_pulse();
      for (int k = 1; k <= 13; k++)
         drive(k, (k >= 11) ? k - 4 : -1, (k >= 11) ? k - 6 : -1, "count_1_13");
      repeat (4) @(negedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
